// File: rtl/timer_ctrl_if.sv
// Host/counter-side bundle for timer_ctrl: control strobes, register write
// port, counter feedback and status outputs.
interface timer_ctrl_if #(
    parameter int CNT_W = 20
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             wr_en;
    logic [1:0]       wr_addr;
    logic [CNT_W-1:0] wr_data;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_en;
    logic             cnt_clr;
    logic             irq;
    logic             busy;
    logic [1:0]       state;
    logic             err;

    modport master (
        output start, stop, pause, wr_en, wr_addr, wr_data, cnt_val,
        input  cnt_en, cnt_clr, irq, busy, state, err
    );

    modport slave (
        input  start, stop, pause, wr_en, wr_addr, wr_data, cnt_val,
        output cnt_en, cnt_clr, irq, busy, state, err
    );
endinterface

// File: rtl/timer_ctrl.sv
// Sequencer for an external nibble-Gray counter: prescaled count enable,
// match expiry with sticky irq, shadowed MATCH/PSC, pause and stop.
module timer_ctrl #(
    parameter int CNT_W = 20,
    parameter int PSC_W = 8
) (
    input logic         clk,
    input logic         clr_n,
    timer_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [1:0] A_CTRL  = 2'd0;
    localparam logic [1:0] A_MATCH = 2'd1;
    localparam logic [1:0] A_PSC   = 2'd2;

    state_e           state_q;
    logic             mode_q;
    logic             cnt_clr_q;
    logic             irq_q;
    logic             err_q;
    logic [CNT_W-1:0] match_sh_q;
    logic [CNT_W-1:0] match_act_q;
    logic [PSC_W-1:0] psc_sh_q;
    logic [PSC_W-1:0] psc_act_q;
    logic [PSC_W-1:0] psc_cnt_q;
    logic [PSC_W-1:0] psc_cnt_d;

    logic [CNT_W-1:0] cnt_bin;
    logic             running;
    logic             at_match;
    logic             expire;
    logic             psc_tick;
    logic             wr_ctrl;
    logic             wr_match;
    logic             wr_psc;
    logic             stop_hit;
    logic             start_req;

    // Each nibble is Gray-coded on its own; decode nibble by nibble.
    function automatic logic [CNT_W-1:0] ngray2bin(
        input logic [CNT_W-1:0] g
    );
        logic [CNT_W-1:0] b;
        b = g;
        for (int i = CNT_W - 2; i >= 0; i--) begin
            if ((i % 4) != 3) begin
                b[i] = g[i] ^ b[i+1];
            end
        end
        return b;
    endfunction

    assign cnt_bin   = ngray2bin(bus.cnt_val);
    assign running   = (state_q == RUN) && !cnt_clr_q;
    assign at_match  = (cnt_bin == match_act_q);
    assign expire    = running && at_match;
    assign psc_tick  = (psc_cnt_q == psc_act_q);
    assign psc_cnt_d = psc_tick ? '0 : psc_cnt_q + 1'b1;

    assign wr_ctrl   = bus.wr_en && (bus.wr_addr == A_CTRL);
    assign wr_match  = bus.wr_en && (bus.wr_addr == A_MATCH);
    assign wr_psc    = bus.wr_en && (bus.wr_addr == A_PSC);

    assign stop_hit  = bus.stop && (state_q != IDLE);
    assign start_req = bus.start && !bus.stop;

    assign bus.cnt_en  = running && psc_tick && !at_match;
    assign bus.cnt_clr = cnt_clr_q;
    assign bus.irq     = irq_q;
    assign bus.err     = err_q;
    assign bus.state   = state_q;
    assign bus.busy    = (state_q == RUN) || (state_q == PAUSE);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q     <= IDLE;
            mode_q      <= 1'b0;
            cnt_clr_q   <= 1'b0;
            irq_q       <= 1'b0;
            err_q       <= 1'b0;
            match_sh_q  <= '0;
            match_act_q <= '0;
            psc_sh_q    <= '0;
            psc_act_q   <= '0;
            psc_cnt_q   <= '0;
        end else begin
            cnt_clr_q <= 1'b0;

            unique case (1'b1)
                wr_ctrl: begin
                    mode_q <= bus.wr_data[0];
                    if (bus.wr_data[1]) begin
                        irq_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                end
                wr_match: match_sh_q <= bus.wr_data;
                wr_psc:   psc_sh_q   <= bus.wr_data[PSC_W-1:0];
                default: ;
            endcase

            // Later assignments override the CTRL clear above.
            if (stop_hit) begin
                state_q   <= IDLE;
                cnt_clr_q <= 1'b1;
            end else begin
                case (state_q)
                    IDLE, DONE: begin
                        if (start_req) begin
                            if (match_sh_q != '0) begin
                                state_q     <= RUN;
                                cnt_clr_q   <= 1'b1;
                                psc_cnt_q   <= '0;
                                match_act_q <= match_sh_q;
                                psc_act_q   <= psc_sh_q;
                            end else begin
                                err_q <= 1'b1;
                            end
                        end
                    end
                    RUN: begin
                        if (expire) begin
                            cnt_clr_q <= 1'b1;
                            irq_q     <= 1'b1;
                            psc_cnt_q <= '0;
                            if (mode_q) begin
                                match_act_q <= match_sh_q;
                                psc_act_q   <= psc_sh_q;
                            end else begin
                                state_q <= DONE;
                            end
                        end else begin
                            psc_cnt_q <= psc_cnt_d;
                            if (bus.pause) begin
                                state_q <= PAUSE;
                            end
                        end
                    end
                    PAUSE: begin
                        if (!bus.pause) begin
                            state_q <= RUN;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule
